// File: rtl/fetch_prefetch_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface fetch_prefetch_if #(
    parameter int unsigned DWIDTH = 32
);
    logic              imem_req_o;
    logic [DWIDTH-1:0] imem_addr_o;
    logic              imem_gnt_i;
    logic              imem_rvalid_i;
    logic [DWIDTH-1:0] imem_rdata_i;

    // Fetch stage issues requests and consumes grants/responses.
    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    // Memory side accepts requests and returns in-order responses.
    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/fetch_prefetch.sv
// Fetch stage with an in-order instruction prefetch queue.
// Requests are issued on credit (queue entries + in-flight responses), so the
// queue can never overflow. A flush redirects the fetch PC, empties the queue
// and turns every in-flight response into one that must be dropped on arrival.
module fetch_prefetch #(
    parameter int unsigned       DWIDTH    = 32,
    parameter int unsigned       QDEPTH    = 4,
    parameter logic [DWIDTH-1:0] PC_INIT   = 32'h0000_0000,
    parameter logic [DWIDTH-1:0] INSTR_NOP = 32'h0000_0013
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core_N,
    fetch_prefetch_if.master  imem,
    input  logic              flush_fi,
    input  logic [DWIDTH-1:0] pc_imm_fi,
    input  logic              stall_fi,
    output logic              valid_fo,
    output logic [DWIDTH-1:0] pc_fo,
    output logic [DWIDTH-1:0] pc_plus_fo,
    output logic [DWIDTH-1:0] instruct_fo
);
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned SW = CW + 2;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    // Circular pointer advance that also works for non-power-of-two depths.
    function automatic ptr_t ptrInc(input ptr_t p);
        ptrInc = (p == ptr_t'(QDEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    logic [DWIDTH-1:0] fpc_q, fpc_d;
    cnt_t              occCnt_q, occCnt_d;
    cnt_t              outstCnt_q, outstCnt_d;
    cnt_t              dropCnt_q, dropCnt_d;
    ptr_t              qHead_q, qHead_d;
    ptr_t              qTail_q, qTail_d;
    ptr_t              tagHead_q, tagHead_d;
    ptr_t              tagTail_q, tagTail_d;

    logic [DWIDTH-1:0] qPc_q    [QDEPTH];
    logic [DWIDTH-1:0] qInstr_q [QDEPTH];
    logic [DWIDTH-1:0] tagPc_q  [QDEPTH];

    logic [SW-1:0]     creditSum;
    logic              reqValid;
    logic              grantFire;
    logic              tagsPending;
    logic              respAccept;
    logic              respKeep;
    logic              headValid;
    logic              popFire;

    // Handshake qualification: credits, grant, response routing and pop.
    always_comb begin
        creditSum   = SW'(occCnt_q) + SW'(outstCnt_q) + SW'(dropCnt_q);
        reqValid    = Rst_Core_N && !flush_fi && (creditSum < SW'(QDEPTH));
        grantFire   = reqValid && imem.imem_gnt_i;
        tagsPending = (outstCnt_q != '0) || (dropCnt_q != '0);
        respAccept  = imem.imem_rvalid_i && tagsPending;
        respKeep    = respAccept && (dropCnt_q == '0) && !flush_fi;
        headValid   = (occCnt_q != '0);
        popFire     = headValid && !stall_fi && !flush_fi;
    end

    // Next-state for fetch PC, counters and FIFO pointers; flush wins over all.
    always_comb begin
        fpc_d      = fpc_q;
        occCnt_d   = occCnt_q;
        outstCnt_d = outstCnt_q;
        dropCnt_d  = dropCnt_q;
        qHead_d    = qHead_q;
        qTail_d    = qTail_q;
        tagHead_d  = tagHead_q;
        tagTail_d  = tagTail_q;

        if (flush_fi) begin
            fpc_d      = {pc_imm_fi[DWIDTH-1:2], 2'b00};
            occCnt_d   = '0;
            qHead_d    = '0;
            qTail_d    = '0;
            outstCnt_d = '0;
            dropCnt_d  = dropCnt_q + outstCnt_q - cnt_t'(respAccept);
        end else begin
            if (grantFire) begin
                fpc_d = fpc_q + DWIDTH'(4);
            end
            outstCnt_d = outstCnt_q + cnt_t'(grantFire) - cnt_t'(respKeep);
            dropCnt_d  = dropCnt_q - cnt_t'(respAccept && !respKeep);
            occCnt_d   = occCnt_q + cnt_t'(respKeep) - cnt_t'(popFire);
            if (respKeep) begin
                qTail_d = ptrInc(qTail_q);
            end
            if (popFire) begin
                qHead_d = ptrInc(qHead_q);
            end
        end

        if (grantFire) begin
            tagTail_d = ptrInc(tagTail_q);
        end
        if (respAccept) begin
            tagHead_d = ptrInc(tagHead_q);
        end
    end

    // State registers; reset abandons everything in flight.
    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            fpc_q      <= PC_INIT;
            occCnt_q   <= '0;
            outstCnt_q <= '0;
            dropCnt_q  <= '0;
            qHead_q    <= '0;
            qTail_q    <= '0;
            tagHead_q  <= '0;
            tagTail_q  <= '0;
        end else begin
            fpc_q      <= fpc_d;
            occCnt_q   <= occCnt_d;
            outstCnt_q <= outstCnt_d;
            dropCnt_q  <= dropCnt_d;
            qHead_q    <= qHead_d;
            qTail_q    <= qTail_d;
            tagHead_q  <= tagHead_d;
            tagTail_q  <= tagTail_d;
        end
    end

    // FIFO storage; validity is tracked entirely by the pointers and counters.
    always_ff @(posedge Clk_Core) begin
        if (grantFire) begin
            tagPc_q[tagTail_q] <= fpc_q;
        end
        if (respKeep) begin
            qPc_q[qTail_q]    <= tagPc_q[tagHead_q];
            qInstr_q[qTail_q] <= imem.imem_rdata_i;
        end
    end

    // Decode-facing view of the queue head; NOP whenever the queue is empty.
    always_comb begin
        valid_fo    = headValid;
        pc_fo       = headValid ? qPc_q[qHead_q] : fpc_q;
        pc_plus_fo  = pc_fo + DWIDTH'(4);
        instruct_fo = headValid ? qInstr_q[qHead_q] : INSTR_NOP;
    end

    assign imem.imem_req_o  = reqValid;
    assign imem.imem_addr_o = fpc_q;
endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: cycle vectors for streaming,
// back-pressure and flush, hand sequences for the multi-cycle corners, and a
// randomized run checked against a reference PC model.
module tb_fetch_prefetch;
    localparam int          QD  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] pcImm;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] ePc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    logic        clk;
    logic        rstN;
    logic        flush;
    logic        stall;
    logic [31:0] pcImm;
    logic        valid;
    logic [31:0] pcFo, pcPlus, instr;
    logic        tieLow;
    logic [31:0] tieWord;
    logic        valid2;
    logic [31:0] pcFo2, pcPlus2, instr2;

    int checkCnt = 0;
    int passCnt  = 0;

    vec_t vecs [27];
    rsp_t pendQ[$];
    int   cycleCnt, lastDue, memLat, latCalc, dueCalc;
    bit   randLat, gntRandom, gntEnable, spurious;
    logic sampFire;
    logic [31:0] sampAddr;
    logic fire2;
    logic [31:0] addr2;

    assign tieLow  = 1'b0;
    assign tieWord = 32'h0;

    fetch_prefetch_if #(.DWIDTH(32)) bus  ();
    fetch_prefetch_if #(.DWIDTH(32)) bus2 ();

    fetch_prefetch #(.DWIDTH(32), .QDEPTH(QD), .PC_INIT(32'h0000_0000), .INSTR_NOP(NOP)) dut (
        .Clk_Core(clk), .Rst_Core_N(rstN), .imem(bus),
        .flush_fi(flush), .pc_imm_fi(pcImm), .stall_fi(stall),
        .valid_fo(valid), .pc_fo(pcFo), .pc_plus_fo(pcPlus), .instruct_fo(instr)
    );

    fetch_prefetch #(.DWIDTH(32), .QDEPTH(QD), .PC_INIT(32'hFFFF_FFF8), .INSTR_NOP(NOP)) dutWrap (
        .Clk_Core(clk), .Rst_Core_N(rstN), .imem(bus2),
        .flush_fi(tieLow), .pc_imm_fi(tieWord), .stall_fi(tieLow),
        .valid_fo(valid2), .pc_fo(pcFo2), .pc_plus_fo(pcPlus2), .instruct_fo(instr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word the memory returns for a given address.
    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_0000;
    endfunction

    // Capture the handshake well away from the clock edge.
    always @(negedge clk) begin
        sampFire = bus.imem_req_o && bus.imem_gnt_i;
        sampAddr = bus.imem_addr_o;
        fire2    = bus2.imem_req_o && bus2.imem_gnt_i;
        addr2    = bus2.imem_addr_o;
    end

    // In-order memory model with configurable or random latency.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pendQ.delete();
            cycleCnt = 0;
            lastDue  = 0;
            sampFire = 1'b0;
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = 32'h0;
            bus.imem_gnt_i    = gntEnable;
        end else begin
            #1;
            cycleCnt++;
            if (sampFire) begin
                latCalc = randLat ? int'($urandom_range(1, 5)) : memLat;
                dueCalc = cycleCnt + latCalc - 1;
                if (dueCalc <= lastDue) dueCalc = lastDue + 1;
                lastDue = dueCalc;
                pendQ.push_back('{addr: sampAddr, due: dueCalc});
            end
            if (pendQ.size() > 0 && pendQ[0].due <= cycleCnt) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = instrOf(pendQ[0].addr);
                void'(pendQ.pop_front());
            end else if (spurious) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = 32'hDEAD_BEEF;
            end else begin
                bus.imem_rvalid_i = 1'b0;
            end
            bus.imem_gnt_i = gntEnable && (gntRandom ? ($urandom_range(0, 99) < 70) : 1'b1);
        end
    end

    // Fixed-latency-1 memory for the wrap-around instance.
    assign bus2.imem_gnt_i = 1'b1;
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            bus2.imem_rvalid_i = 1'b0;
            bus2.imem_rdata_i  = 32'h0;
        end else begin
            #1;
            bus2.imem_rvalid_i = fire2;
            bus2.imem_rdata_i  = instrOf(addr2);
        end
    end

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic vec_t mkVec(input logic s, input logic f, input logic [31:0] imm,
                                   input logic eReq, input logic [31:0] eAddr,
                                   input logic eValid, input logic [31:0] ePc);
        vec_t v;
        v.stall = s; v.flush = f; v.pcImm = imm;
        v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid; v.ePc = ePc;
        return v;
    endfunction

    task automatic applyStimulus(input logic s, input logic f, input logic [31:0] imm);
        stall = s;
        flush = f;
        pcImm = imm;
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        cmp($sformatf("%s.req", tag), 32'(bus.imem_req_o), 32'(v.eReq));
        cmp($sformatf("%s.addr", tag), bus.imem_addr_o, v.eAddr);
        cmp($sformatf("%s.valid", tag), 32'(valid), 32'(v.eValid));
        if (v.eValid) begin
            cmp($sformatf("%s.pc", tag), pcFo, v.ePc);
            cmp($sformatf("%s.pcplus", tag), pcPlus, v.ePc + 32'd4);
            cmp($sformatf("%s.instr", tag), instr, instrOf(v.ePc));
        end else begin
            cmp($sformatf("%s.nop", tag), instr, NOP);
        end
    endtask

    // Follow the queue head until 'count' instructions are seen (stall is low).
    task automatic expectStream(input string tag, input logic [31:0] startPc,
                                input int count, input int budget);
        logic [31:0] e   = startPc;
        int          got = 0;
        int          cyc = 0;
        while (got < count && cyc < budget) begin
            @(negedge clk);
            if (valid) begin
                cmp($sformatf("%s.pc%0d", tag, got), pcFo, e);
                cmp($sformatf("%s.instr%0d", tag, got), instr, instrOf(e));
                e = e + 32'd4;
                got++;
            end
            cyc++;
        end
        cmp($sformatf("%s.count", tag), 32'(got), 32'(count));
    endtask

    task automatic doReset();
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        rstN = 1'b1;
    endtask

    initial begin
        logic [31:0] wAddr [5];
        logic [31:0] wPc   [5];
        logic        wValid[5];
        logic [31:0] expPc;
        int          liveCnt, maxLive, pops;

        rstN = 1'b0;
        memLat = 1; randLat = 1'b0; gntRandom = 1'b0; gntEnable = 1'b1; spurious = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Stream, 10-cycle stall, release, flush coincident with rvalid and stall.
        for (int i = 0; i <= 4; i++)
            vecs[i] = mkVec(0, 0, 0, 1, 32'(4 * i), (i >= 2), 32'(4 * (i - 2)));
        vecs[5]  = mkVec(1, 0, 0, 1, 32'h14, 1, 32'h0C);
        vecs[6]  = mkVec(1, 0, 0, 1, 32'h18, 1, 32'h0C);
        for (int i = 7; i <= 14; i++)
            vecs[i] = mkVec(1, 0, 0, 0, 32'h1C, 1, 32'h0C);
        vecs[15] = mkVec(0, 0, 0, 0, 32'h1C, 1, 32'h0C);
        vecs[16] = mkVec(0, 0, 0, 1, 32'h1C, 1, 32'h10);
        vecs[17] = mkVec(0, 0, 0, 1, 32'h20, 1, 32'h14);
        vecs[18] = mkVec(0, 0, 0, 1, 32'h24, 1, 32'h18);
        vecs[19] = mkVec(0, 0, 0, 1, 32'h28, 1, 32'h1C);
        vecs[20] = mkVec(0, 0, 0, 1, 32'h2C, 1, 32'h20);
        vecs[21] = mkVec(0, 0, 0, 1, 32'h30, 1, 32'h24);
        vecs[22] = mkVec(1, 1, 32'h103, 0, 32'h34, 1, 32'h28);
        vecs[23] = mkVec(0, 0, 0, 1, 32'h100, 0, 32'h0);
        vecs[24] = mkVec(0, 0, 0, 1, 32'h104, 0, 32'h0);
        vecs[25] = mkVec(0, 0, 0, 1, 32'h108, 1, 32'h100);
        vecs[26] = mkVec(0, 0, 0, 1, 32'h10C, 1, 32'h104);

        // Outputs while reset is held.
        repeat (2) @(negedge clk);
        cmp("rst.req", 32'(bus.imem_req_o), 32'd0);
        cmp("rst.valid", 32'(valid), 32'd0);
        cmp("rst.instr", instr, NOP);
        cmp("rst.pc", pcFo, 32'h0);
        cmp("rst.addr", bus.imem_addr_o, 32'h0);
        cmp("rst.wrapPc", pcFo2, 32'hFFFF_FFF8);
        cmp("rst.wrapReq", 32'(bus2.imem_req_o), 32'd0);

        @(posedge clk);
        #2;
        rstN = 1'b1;
        for (int i = 0; i < 27; i++) begin
            applyStimulus(vecs[i].stall, vecs[i].flush, vecs[i].pcImm);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
            @(posedge clk);
            #2;
        end

        // Flush with three requests in flight (latency 4).
        memLat = 4;
        doReset();
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        applyStimulus(1'b0, 1'b1, 32'h103);
        @(negedge clk);
        cmp("flush3.reqLow", 32'(bus.imem_req_o), 32'd0);
        @(posedge clk);
        #2;
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        cmp("flush3.req", 32'(bus.imem_req_o), 32'd1);
        cmp("flush3.addr", bus.imem_addr_o, 32'h100);
        cmp("flush3.valid", 32'(valid), 32'd0);
        expectStream("flush3", 32'h100, 3, 30);

        // Response with nothing in flight must be ignored.
        memLat = 1;
        gntEnable = 1'b0;
        doReset();
        spurious = 1'b1;
        @(posedge clk);
        #2;
        spurious = 1'b0;
        @(posedge clk);
        #2;
        @(negedge clk);
        cmp("spur.valid", 32'(valid), 32'd0);
        cmp("spur.instr", instr, NOP);
        cmp("spur.addr", bus.imem_addr_o, 32'h0);
        gntEnable = 1'b1;
        expectStream("spur", 32'h0, 2, 20);

        // PC wrap-around on the second instance.
        wAddr  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
        wValid = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        wPc    = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        doReset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmp($sformatf("wrap%0d.addr", i), bus2.imem_addr_o, wAddr[i]);
            cmp($sformatf("wrap%0d.valid", i), 32'(valid2), 32'(wValid[i]));
            if (wValid[i]) begin
                cmp($sformatf("wrap%0d.pc", i), pcFo2, wPc[i]);
                cmp($sformatf("wrap%0d.pcplus", i), pcPlus2, wPc[i] + 32'd4);
                cmp($sformatf("wrap%0d.instr", i), instr2, instrOf(wPc[i]));
            end
        end

        // Random grant, latency, stall and flush against a reference PC model.
        randLat = 1'b1;
        gntRandom = 1'b1;
        doReset();
        expPc = 32'h0;
        liveCnt = 0;
        maxLive = 0;
        pops = 0;
        for (int c = 0; c < 600; c++) begin
            applyStimulus($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 3, $urandom);
            @(negedge clk);
            if (flush) begin
                expPc = {pcImm[31:2], 2'b00};
                liveCnt = 0;
            end else begin
                if (valid && !stall) begin
                    cmp($sformatf("rand%0d.pc", c), pcFo, expPc);
                    cmp($sformatf("rand%0d.instr", c), instr, instrOf(expPc));
                    expPc = expPc + 32'd4;
                    liveCnt--;
                    pops++;
                end
                if (bus.imem_req_o && bus.imem_gnt_i) liveCnt++;
                if (liveCnt > maxLive) maxLive = liveCnt;
            end
            @(posedge clk);
            #2;
        end
        cmp("rand.noOverflow", 32'(maxLive <= QD), 32'd1);
        cmp("rand.progress", 32'(pops >= 50), 32'd1);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
